// File: rtl/qaddsub_pkg.sv
// qaddsub_pkg: shared definitions for the sign-magnitude add/sub pipeline.
//   OP_ADD / OP_SUB : op select encoding (op input of qaddsub_pipe)
//   SM_MAX_W        : widest magnitude the zero test accepts
//   sm_is_zero()    : sign-magnitude zero test on a zero-extended magnitude;
//                     the sign bit is ignored, so negative zero counts as zero
package qaddsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int SM_MAX_W = 64;

    function automatic logic sm_is_zero(input logic [SM_MAX_W-1:0] mag);
        return mag == '0;
    endfunction

endpackage

// File: rtl/qaddsub_pipe_sm_mag_core.sv
// sm_mag_core: combinational magnitude datapath for sign-magnitude arithmetic.
//   ma, mb : W-bit unsigned magnitudes
//   sum    : ma + mb with carry in bit W
//   ge     : ma >= mb
//   diff   : |ma - mb| (never negative, so no borrow to track)
module sm_mag_core #(
    parameter int W = 31
) (
    input  logic [W-1:0] ma,
    input  logic [W-1:0] mb,
    output logic [W:0]   sum,
    output logic         ge,
    output logic [W-1:0] diff
);

    assign sum  = {1'b0, ma} + {1'b0, mb};
    assign ge   = (ma >= mb);
    assign diff = ge ? (ma - mb) : (mb - ma);

endmodule

// File: rtl/qaddsub_pipe.sv
// qaddsub_pipe: two-stage pipelined sign-magnitude fixed-point adder/subtractor
// with valid/ready handshakes on both sides.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : input handshake for a, b, op, in_tag
//   a, b                  : N-bit sign-magnitude operands (bit N-1 = sign)
//   op                    : OP_ADD (A+B) or OP_SUB (A-B)
//   in_tag / out_tag      : user tag carried through unchanged
//   out_valid/out_ready   : output handshake for c, out_tag, ovf
//   c                     : result, never negative zero
//   ovf                   : magnitude overflow for this result
//   ovf_cnt / cnt_clr     : saturating count of transferred overflow results,
//                           synchronous clear (clear wins over increment)
// Build option: QADDSUB_SAT_EN - saturate magnitude on overflow instead of wrapping.
// Q only fixes where the binary point sits; the logic does not depend on it.
module qaddsub_pipe
    import qaddsub_pkg::*;
#(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     c,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             cnt_clr
);

    localparam int M      = N - 1;   // magnitude width
    localparam int STAGES = 2;

    if (N < 4 || M > SM_MAX_W || Q < 0 || Q > N - 2 || TAG_W < 1 || CNT_W < 1) begin : g_bad_params
        $error("qaddsub_pipe: illegal parameter combination");
    end

    // Stage-1 payload: resolved sign, raw magnitude, add carry, tag
    typedef struct packed {
        logic             sign;
        logic [M-1:0]     mag;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    logic            adv1, adv2;
    s1_t             s1_d, s1_q;

    // ---------------- handshake ----------------
    assign adv2      = !vld_pipe[2] || out_ready;
    assign adv1      = adv2 || !vld_pipe[1];
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];

    // ---------------- stage 1 ----------------
    logic         sa, sb, ge;
    logic [M:0]   sum;
    logic [M-1:0] diff;

    assign sa = a[N-1];
    assign sb = b[N-1] ^ (op != OP_ADD);

    sm_mag_core #(.W(M)) u_core (
        .ma   (a[M-1:0]),
        .mb   (b[M-1:0]),
        .sum  (sum),
        .ge   (ge),
        .diff (diff)
    );

    always_comb begin
        s1_d     = '0;
        s1_d.tag = in_tag;
        if (sa == sb) begin
            s1_d.sign  = sa;
            s1_d.mag   = sum[M-1:0];
            s1_d.carry = sum[M];
        end else begin
            // unlike signs: the larger magnitude decides the sign; a tie
            // gives zero, which stage 2 normalises to +0
            s1_d.sign  = ge ? sa : sb;
            s1_d.mag   = diff;
            s1_d.carry = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_q        <= '0;
        end else if (adv1) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    // ---------------- stage 2 ----------------
    logic [M-1:0] mag2;
    logic         sign2;

    always_comb begin
        mag2 = s1_q.mag;
`ifdef QADDSUB_SAT_EN
        if (s1_q.carry) mag2 = '1;
`endif
        // a zero magnitude (including a wrapped overflow) always leaves as +0
        sign2 = s1_q.sign && !sm_is_zero(SM_MAX_W'(mag2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            c           <= '0;
            ovf         <= 1'b0;
            out_tag     <= '0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                c       <= {sign2, mag2};
                ovf     <= s1_q.carry;
                out_tag <= s1_q.tag;
            end
        end
    end

    // ---------------- overflow counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && ovf && ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule
